// File: rtl/io_bus_mailbox_responder.sv
// rtl/io_bus_mailbox_responder.sv - HPS IO bridge target exposing a 16-bit TX/RX mailbox to fabric
module io_bus_mailbox_responder #(
    parameter logic [15:0] BASE        = 16'h0100,
    parameter logic [15:0] ID_VALUE    = 16'h391A,
    parameter int          FIFO_DEPTH  = 16,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] io_address,
    input  logic        io_bus_enable,
    input  logic        io_rw,
    input  logic [1:0]  io_byte_enable,
    input  logic [15:0] io_write_data,
    output logic [15:0] io_read_data,
    output logic        io_acknowledge,
    output logic        io_irq,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] rx_data,
    input  logic        rx_valid
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
    localparam bit NO_WAIT = (WAIT_STATES == 0);
    localparam logic [2:0] WS_M1 = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    localparam logic [2:0] REG_ID      = 3'd0;
    localparam logic [2:0] REG_CTRL    = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_DATA    = 3'd3;
    localparam logic [2:0] REG_SCRATCH = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t      state;
    logic [2:0]  wait_cnt;
    logic [2:0]  lat_reg;
    logic        lat_rw;
    logic [1:0]  lat_be;
    logic [15:0] lat_wdata;

    logic        req;
    logic        fire;
    logic [2:0]  acc_reg;
    logic        acc_rw;
    logic [1:0]  acc_be;
    logic [15:0] acc_wdata;
    logic [15:0] rd_val;

    logic [1:0]  ctrl;
    logic [15:0] scratch;
    logic        rx_ovf;
    logic        tx_ovf;

    logic [15:0]   tx_mem [FIFO_DEPTH];
    logic [15:0]   rx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [PW-1:0] tx_count, rx_count;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]    rx_count_sat;
    logic [15:0]   status_word;

    logic wr_acc, rd_acc;
    logic ctrl_wr, flush, stat_w1c, data_wr, data_rd, scr_wr;
    logic tx_pop, tx_push_ok, tx_drop;
    logic rx_pop, rx_push_ok, rx_drop;

    // Address bit 0 selects a byte within a 16-bit register and carries no meaning here.
    logic unused_addr_bit;
    assign unused_addr_bit = io_address[0];

    assign req = io_bus_enable && (io_address[15:4] == BASE[15:4]);

    // Choose live or latched request fields and flag the single cycle an access takes effect.
    always_comb begin
        fire      = 1'b0;
        acc_reg   = io_address[3:1];
        acc_rw    = io_rw;
        acc_be    = io_byte_enable;
        acc_wdata = io_write_data;
        if (state == S_WAIT) begin
            acc_reg   = lat_reg;
            acc_rw    = lat_rw;
            acc_be    = lat_be;
            acc_wdata = lat_wdata;
            fire      = io_bus_enable && (wait_cnt == 3'd0);
        end else if (state == S_IDLE) begin
            fire = NO_WAIT && req;
        end
    end

    assign wr_acc   = fire && !acc_rw;
    assign rd_acc   = fire && acc_rw;
    assign ctrl_wr  = wr_acc && (acc_reg == REG_CTRL);
    assign flush    = ctrl_wr && acc_be[1] && acc_wdata[15];
    assign stat_w1c = wr_acc && (acc_reg == REG_STATUS) && acc_be[0];
    assign data_wr  = wr_acc && (acc_reg == REG_DATA) && (acc_be == 2'b11);
    assign scr_wr   = wr_acc && (acc_reg == REG_SCRATCH);
    assign data_rd  = rd_acc && (acc_reg == REG_DATA);

    assign tx_count = tx_wptr - tx_rptr;
    assign rx_count = rx_wptr - rx_rptr;
    assign tx_full  = (tx_count == DEPTH_P);
    assign rx_full  = (rx_count == DEPTH_P);
    assign tx_empty = (tx_count == '0);
    assign rx_empty = (rx_count == '0);

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_mem[tx_rptr[AW-1:0]];

    // A slot freed by a same-cycle pop is immediately reusable, so a full FIFO only drops when idle.
    assign tx_pop     = tx_valid && tx_ready;
    assign tx_push_ok = data_wr && (!tx_full || tx_pop);
    assign tx_drop    = data_wr && tx_full && !tx_pop;
    assign rx_pop     = data_rd && !rx_empty;
    assign rx_push_ok = rx_valid && (!rx_full || rx_pop);
    assign rx_drop    = rx_valid && rx_full && !rx_pop;

    // Saturate the RX occupancy to the 8-bit STATUS field.
    always_comb begin
        rx_count_sat = 8'(rx_count);
        if (int'(rx_count) > 255) begin
            rx_count_sat = 8'hFF;
        end
    end

    assign status_word = {rx_count_sat, 4'h0, tx_ovf, rx_ovf, tx_full, !rx_empty};

    // Read multiplexer over the register window; unused offsets read as zero.
    always_comb begin
        rd_val = 16'h0000;
        case (acc_reg)
            REG_ID:      rd_val = ID_VALUE;
            REG_CTRL:    rd_val = {14'h0000, ctrl};
            REG_STATUS:  rd_val = status_word;
            REG_DATA:    rd_val = rx_empty ? 16'h0000 : rx_mem[rx_rptr[AW-1:0]];
            REG_SCRATCH: rd_val = scratch;
            default:     rd_val = 16'h0000;
        endcase
    end

    // Bus handshake FSM with registered acknowledge and read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            wait_cnt       <= 3'd0;
            lat_reg        <= 3'd0;
            lat_rw         <= 1'b0;
            lat_be         <= 2'b00;
            lat_wdata      <= 16'h0000;
            io_acknowledge <= 1'b0;
            io_read_data   <= 16'h0000;
        end else begin
            io_acknowledge <= fire;
            io_read_data   <= rd_acc ? rd_val : 16'h0000;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        lat_reg   <= io_address[3:1];
                        lat_rw    <= io_rw;
                        lat_be    <= io_byte_enable;
                        lat_wdata <= io_write_data;
                        wait_cnt  <= WS_M1;
                        state     <= NO_WAIT ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!io_bus_enable) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == 3'd0) begin
                        state <= S_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_ACK: begin
                    state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!io_bus_enable) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Control, scratch and sticky overflow flags; a new overflow beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl    <= 2'b00;
            scratch <= 16'h0000;
            rx_ovf  <= 1'b0;
            tx_ovf  <= 1'b0;
        end else begin
            if (ctrl_wr && acc_be[0]) begin
                ctrl <= acc_wdata[1:0];
            end
            if (scr_wr && acc_be[0]) begin
                scratch[7:0] <= acc_wdata[7:0];
            end
            if (scr_wr && acc_be[1]) begin
                scratch[15:8] <= acc_wdata[15:8];
            end
            if (rx_drop) begin
                rx_ovf <= 1'b1;
            end else if (stat_w1c && acc_wdata[2]) begin
                rx_ovf <= 1'b0;
            end
            if (tx_drop) begin
                tx_ovf <= 1'b1;
            end else if (stat_w1c && acc_wdata[3]) begin
                tx_ovf <= 1'b0;
            end
        end
    end

    // FIFO pointers; a flush overrides any same-cycle push or pop on either side.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else if (flush) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (tx_push_ok) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)     tx_rptr <= tx_rptr + 1'b1;
            if (rx_push_ok) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)     rx_rptr <= rx_rptr + 1'b1;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (tx_push_ok) tx_mem[tx_wptr[AW-1:0]] <= acc_wdata;
        if (rx_push_ok) rx_mem[rx_wptr[AW-1:0]] <= rx_data;
    end

    // Level interrupt registered from the current FIFO state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_irq <= 1'b0;
        end else begin
            io_irq <= (ctrl[0] && !rx_empty) || (ctrl[1] && tx_empty);
        end
    end

endmodule

// File: tb/tb_io_bus_mailbox_responder.sv
// tb/tb_io_bus_mailbox_responder.sv - directed plus randomized bench for io_bus_mailbox_responder
module tb_io_bus_mailbox_responder;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_en, rw, sel;
    logic [15:0] addr, wd;
    logic [1:0]  be;
    logic        tx_ready, rx_valid;
    logic [15:0] rx_data;
    logic [15:0] rd0, rd1, txd0, txd1;
    logic        ack0, ack1, irq0, irq1, txv0, txv1;
    logic        ack, irq;
    logic [15:0] rdx;

    always #5 clk = ~clk;

    io_bus_mailbox_responder #(.BASE(16'h0100), .ID_VALUE(16'h391A), .FIFO_DEPTH(DEPTH), .WAIT_STATES(0)) dut (
        .clk(clk), .reset(reset), .io_address(addr), .io_bus_enable(bus_en & ~sel), .io_rw(rw),
        .io_byte_enable(be), .io_write_data(wd), .io_read_data(rd0), .io_acknowledge(ack0), .io_irq(irq0),
        .tx_data(txd0), .tx_valid(txv0), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid)
    );

    io_bus_mailbox_responder #(.BASE(16'h0100), .ID_VALUE(16'h391A), .FIFO_DEPTH(DEPTH), .WAIT_STATES(3)) dut_ws3 (
        .clk(clk), .reset(reset), .io_address(addr), .io_bus_enable(bus_en & sel), .io_rw(rw),
        .io_byte_enable(be), .io_write_data(wd), .io_read_data(rd1), .io_acknowledge(ack1), .io_irq(irq1),
        .tx_data(txd1), .tx_valid(txv1), .tx_ready(1'b0), .rx_data(16'h0000), .rx_valid(1'b0)
    );

    assign ack = sel ? ack1 : ack0;
    assign irq = sel ? irq1 : irq0;
    assign rdx = sel ? rd1 : rd0;

    int tests = 0;
    int fails = 0;
    int exp_lat = 1;

    // Reference model state
    logic [15:0] m_scratch;
    logic [1:0]  m_ctrl;
    logic        m_rx_ovf, m_tx_ovf;
    logic [15:0] m_rx[$];
    logic [15:0] m_tx[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_scratch = 16'h0; m_ctrl = 2'b00; m_rx_ovf = 1'b0; m_tx_ovf = 1'b0;
        m_rx.delete(); m_tx.delete();
    endtask

    function automatic logic [15:0] model_status();
        int n = m_rx.size();
        logic [7:0] c = (n > 255) ? 8'hFF : 8'(n);
        return {c, 4'h0, m_tx_ovf, m_rx_ovf, (m_tx.size() == DEPTH), (n != 0)};
    endfunction

    task automatic model_push_rx(input logic [15:0] w);
        if (m_rx.size() < DEPTH) m_rx.push_back(w);
        else m_rx_ovf = 1'b1;
    endtask

    task automatic model_access(input logic r, input logic [15:0] a, input logic [1:0] b, input logic [15:0] d,
                               output logic [15:0] rexp, output logic flushed);
        rexp = 16'h0; flushed = 1'b0;
        case (a[3:1])
            3'd0: if (r) rexp = 16'h391A;
            3'd1: if (r) rexp = {14'h0, m_ctrl};
                  else begin
                      if (b[0]) m_ctrl = d[1:0];
                      if (b[1] && d[15]) begin m_rx.delete(); m_tx.delete(); flushed = 1'b1; end
                  end
            3'd2: if (r) rexp = model_status();
                  else if (b[0]) begin
                      if (d[2]) m_rx_ovf = 1'b0;
                      if (d[3]) m_tx_ovf = 1'b0;
                  end
            3'd3: if (r) begin
                      if (m_rx.size() > 0) rexp = m_rx.pop_front();
                  end else if (b == 2'b11) begin
                      if (m_tx.size() < DEPTH) m_tx.push_back(d);
                      else m_tx_ovf = 1'b1;
                  end
            3'd4: if (r) rexp = m_scratch;
                  else begin
                      if (b[0]) m_scratch[7:0] = d[7:0];
                      if (b[1]) m_scratch[15:8] = d[15:8];
                  end
            default: ;
        endcase
    endtask

    task automatic bus(input logic r, input logic [15:0] a, input logic [1:0] b, input logic [15:0] d,
                       input int hold, input logic push, input logic [15:0] pw,
                       output logic [15:0] rdata, output int lat, output int extra,
                       output logic irq_a, output logic irq_n);
        @(negedge clk);
        bus_en = 1'b1; rw = r; addr = a; be = b; wd = d;
        if (push) begin rx_valid = 1'b1; rx_data = pw; end
        lat = -1; rdata = 16'h0; extra = 0; irq_a = 1'b0; irq_n = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
            if (ack) begin lat = i; rdata = rdx; irq_a = irq; break; end
        end
        if (lat > 0) begin
            for (int i = 0; i <= hold; i++) begin
                @(posedge clk); #1;
                if (i == 0) irq_n = irq;
                if (ack) extra++;
            end
        end
        @(negedge clk); bus_en = 1'b0;
        @(posedge clk); @(posedge clk);
    endtask

    task automatic op(input string tag, input logic r, input logic [15:0] a, input logic [1:0] b,
                      input logic [15:0] d, input logic push = 1'b0, input logic [15:0] pw = 16'h0);
        logic [15:0] got, expv;
        int lat, extra;
        logic ia, inx, fl;
        model_access(r, a, b, d, expv, fl);
        if (push && !fl) model_push_rx(pw);
        bus(r, a, b, d, 0, push, pw, got, lat, extra, ia, inx);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (r) check(tag, {16'h0, got}, {16'h0, expv});
    endtask

    task automatic rx_push(input logic [15:0] w);
        @(negedge clk); rx_valid = 1'b1; rx_data = w;
        @(posedge clk); #1; rx_valid = 1'b0;
        model_push_rx(w);
    endtask

    initial begin
        logic [15:0] r16, expv;
        int lat, extra, kind;
        logic ia, inx, fl, saw;

        reset = 1'b1; bus_en = 1'b0; rw = 1'b0; sel = 1'b0; addr = 16'h0; wd = 16'h0; be = 2'b00;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 16'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", ack0, 0); check("rst_rdata", rd0, 0); check("rst_irq", irq0, 0);
        check("rst_txv", txv0, 0); check("rst_ack_ws3", ack1, 0);
        @(negedge clk); reset = 1'b0;

        // Identification, window decode and reset register values
        op("id", 1, 16'h0100, 2'b11, 0);
        bus(1, 16'h0200, 2'b11, 0, 0, 0, 0, r16, lat, extra, ia, inx);
        check("out_of_window", 32'(lat), 32'(-1));
        op("ctrl_rst", 1, 16'h0102, 2'b11, 0);
        op("status_rst", 1, 16'h0104, 2'b11, 0);
        op("scratch_rst", 1, 16'h0108, 2'b11, 0);

        // Scratch byte enables and single ack under a held request
        op("scr_w1", 0, 16'h0108, 2'b11, 16'hABCD);
        op("scr_w2", 0, 16'h0108, 2'b10, 16'h1200);
        op("scr_r", 1, 16'h0108, 2'b11, 0);
        model_access(0, 16'h0108, 2'b01, 16'h5555, expv, fl);
        bus(0, 16'h0108, 2'b01, 16'h5555, 3, 0, 0, r16, lat, extra, ia, inx);
        check("hold_extra_acks", 32'(extra), 0);
        op("scr_after_hold", 1, 16'h0108, 2'b11, 0);

        // TX overflow, drain order and W1C
        for (int i = 1; i <= 17; i++) op("tx_w", 0, 16'h0106, 2'b11, 16'(i));
        op("tx_status_full", 1, 16'h0104, 2'b11, 0);
        @(negedge clk); tx_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            check("tx_valid", txv0, 1);
            r16 = m_tx.pop_front();
            check("tx_data", txd0, r16);
            @(negedge clk);
        end
        check("tx_drained", txv0, 0);
        tx_ready = 1'b0;
        op("tx_w1c", 0, 16'h0104, 2'b01, 16'h0008);
        op("tx_status_clr", 1, 16'h0104, 2'b11, 0);
        op("tx_partial_be", 0, 16'h0106, 2'b01, 16'h7777);
        check("tx_partial_ignored", txv0, 0);

        // RX path and interrupt timing
        op("ctrl_rx_en", 0, 16'h0102, 2'b11, 16'h0001);
        @(negedge clk); rx_valid = 1'b1; rx_data = 16'h00A5;
        @(posedge clk); #1; rx_valid = 1'b0;
        model_push_rx(16'h00A5);
        check("irq_not_yet", irq0, 0);
        @(posedge clk); #1;
        check("irq_rise", irq0, 1);
        rx_push(16'h005A);
        op("rx_status2", 1, 16'h0104, 2'b11, 0);
        op("rx_pop1", 1, 16'h0106, 2'b11, 0);
        model_access(1, 16'h0106, 2'b11, 0, expv, fl);
        bus(1, 16'h0106, 2'b11, 0, 0, 0, 0, r16, lat, extra, ia, inx);
        check("rx_pop2", r16, expv);
        check("irq_at_last_pop", ia, 1);
        check("irq_fall", inx, 0);
        op("rx_pop_empty", 1, 16'h0106, 2'b11, 0);
        op("rx_status_empty", 1, 16'h0104, 2'b11, 0);
        op("ctrl_tx_en", 0, 16'h0102, 2'b01, 16'h0002);
        check("irq_tx_empty", irq0, 1);
        op("ctrl_rx_only", 0, 16'h0102, 2'b01, 16'h0001);
        check("irq_off", irq0, 0);

        // RX full, pop+push same cycle, flush with concurrent push
        for (int i = 0; i < DEPTH + 1; i++) rx_push(16'($urandom));
        op("rx_status_full", 1, 16'h0104, 2'b11, 0);
        op("rx_pop_push", 1, 16'h0106, 2'b11, 0, 1'b1, 16'($urandom));
        op("rx_status_still_full", 1, 16'h0104, 2'b11, 0);
        op("flush", 0, 16'h0102, 2'b11, 16'h8001, 1'b1, 16'($urandom));
        op("rx_status_flushed", 1, 16'h0104, 2'b11, 0);
        op("rx_empty_after_flush", 1, 16'h0106, 2'b11, 0);

        // Randomized mix against the model
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 6);
            case (kind)
                0: op("rnd_scr_w", 0, 16'h0108, 2'($urandom), 16'($urandom));
                1: op("rnd_scr_r", 1, 16'h0108, 2'b11, 0);
                2: rx_push(16'($urandom));
                3: op("rnd_data_r", 1, 16'h0106, 2'b11, 0);
                4: op("rnd_status", 1, 16'h0104, 2'b11, 0);
                5: op("rnd_w1c", 0, 16'h0104, 2'b01, 16'($urandom) & 16'h000C);
                default: begin
                    op("rnd_rsv_w", 0, 16'(16'h010A + 2 * $urandom_range(0, 2)), 2'b11, 16'($urandom));
                    op("rnd_rsv_r", 1, 16'(16'h010A + 2 * $urandom_range(0, 2)), 2'b11, 0);
                end
            endcase
        end

        // Wait-state instance: latency, abort and reset during WAIT
        sel = 1'b1; exp_lat = 4;
        op("ws3_id", 1, 16'h0100, 2'b11, 0);
        @(negedge clk); bus_en = 1'b1; rw = 1'b0; addr = 16'h0108; be = 2'b11; wd = 16'h1234;
        @(posedge clk);
        @(negedge clk); bus_en = 1'b0;
        saw = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (ack) saw = 1'b1; end
        check("abort_no_ack", saw, 0);
        bus(1, 16'h0108, 2'b11, 0, 0, 0, 0, r16, lat, extra, ia, inx);
        check("abort_no_write", r16, 16'h0000);
        check("abort_read_lat", 32'(lat), 4);
        @(negedge clk); bus_en = 1'b1; rw = 1'b0; addr = 16'h0108; be = 2'b11; wd = 16'hBEEF;
        @(posedge clk); @(posedge clk); #1;
        check("ws3_no_early_ack", ack1, 0);
        reset = 1'b1; #1;
        check("rst_wait_ack", ack1, 0); check("rst_wait_rdata", rd1, 0);
        check("rst_wait_irq", irq1, 0); check("rst_wait_txv", txv1, 0);
        saw = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (ack1) saw = 1'b1; end
        check("rst_wait_no_ack", saw, 0);
        @(negedge clk); bus_en = 1'b0; reset = 1'b0;
        model_reset();
        op("ws3_scr_after_rst", 1, 16'h0108, 2'b11, 0);
        sel = 1'b0; exp_lat = 1;
        op("scr_after_rst", 1, 16'h0108, 2'b11, 0);
        op("status_after_rst", 1, 16'h0104, 2'b11, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
